// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the program-counter sequencer.
// Used by pc_sequencer (optional call/return link enabled by PC_SEQUENCER_LINK_EN).
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    localparam int PC_RESET = 0;

    // Sign-extends the low imm_w bits of imm to 64 bits; callers size-cast to D.
    function automatic logic [63:0] sext_imm(input logic [63:0] imm, input int imm_w);
        logic signed [63:0] w_shifted;
        w_shifted = $signed(imm << (64 - imm_w));
        return w_shifted >>> (64 - imm_w);
    endfunction

endpackage

// File: rtl/branch_lut.sv
// Branch-offset lookup table: LUT_DEPTH x D register file with one synchronous
// write port and one combinational read port (read returns pre-write contents).
module branch_lut #(
    parameter int D         = 12,
    parameter int LUT_DEPTH = 16,
    parameter int SEL_W     = $clog2(LUT_DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic [SEL_W-1:0] i_waddr,
    input  logic [D-1:0]     i_wdata,
    input  logic [SEL_W-1:0] i_raddr,
    output logic [D-1:0]     o_rdata
);

    logic [D-1:0] r_mem [LUT_DEPTH];

    // NOTE: the table is small and must read back zero after reset, so it is
    // built from resettable flops rather than an inferred RAM macro.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register, IDLE/RUN/DONE control FSM and branch
// target selection. Define PC_SEQUENCER_LINK_EN to add call/ret and a link register.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int D         = 12,
    parameter int IMM_W     = 4,
    parameter int LUT_DEPTH = 16,
    parameter int SEL_W     = $clog2(LUT_DEPTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic             halt,
    input  logic             stall,
    input  logic             branch_en,
    input  logic             imm_or_lut,
    input  logic             abs_sel,
    input  logic [IMM_W-1:0] pc_ctrl_input,
    input  logic             lut_we,
    input  logic [SEL_W-1:0] lut_waddr,
    input  logic [D-1:0]     lut_wdata,
`ifdef PC_SEQUENCER_LINK_EN
    input  logic             call,
    input  logic             ret,
    output logic [D-1:0]     link_addr,
`endif
    output logic [D-1:0]     prog_counter,
    output logic             running,
    output logic             done
);

    localparam logic [D-1:0] PC_ONE  = D'(1);
    localparam logic [D-1:0] PC_INIT = D'(PC_RESET);

    seq_state_e   r_state;
    seq_state_e   w_state_nxt;
    logic [D-1:0] r_pc;
    logic [D-1:0] w_pc_nxt;
    logic [D-1:0] w_lut_rdata;
    logic [D-1:0] w_imm_ext;
    logic [D-1:0] w_branch_tgt;

    branch_lut #(
        .D         (D),
        .LUT_DEPTH (LUT_DEPTH),
        .SEL_W     (SEL_W)
    ) u_lut (
        .i_clk   (Clk),
        .i_rst_n (Reset),
        .i_we    (lut_we),
        .i_waddr (lut_waddr),
        .i_wdata (lut_wdata),
        .i_raddr (pc_ctrl_input[SEL_W-1:0]),
        .o_rdata (w_lut_rdata)
    );

    assign w_imm_ext    = D'(sext_imm(64'(pc_ctrl_input), IMM_W));
    assign w_branch_tgt = !imm_or_lut ? (r_pc + w_imm_ext)
                        : abs_sel     ? w_lut_rdata
                        :               (r_pc + w_lut_rdata);

`ifdef PC_SEQUENCER_LINK_EN
    logic [D-1:0] r_link;
    logic [D-1:0] w_link_nxt;
    assign link_addr = r_link;
`endif

    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
`ifdef PC_SEQUENCER_LINK_EN
        w_link_nxt  = r_link;
`endif
        case (r_state)
            IDLE: begin
                w_pc_nxt = PC_INIT;
                if (start) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (halt) begin
                    w_state_nxt = DONE;
                end else if (!stall) begin
`ifdef PC_SEQUENCER_LINK_EN
                    if (ret) begin
                        w_pc_nxt = r_link;
                    end else if (branch_en || call) begin
                        w_pc_nxt = w_branch_tgt;
                        if (call) begin
                            w_link_nxt = r_pc + PC_ONE;
                        end
                    end else begin
                        w_pc_nxt = r_pc + PC_ONE;
                    end
`else
                    if (branch_en) begin
                        w_pc_nxt = w_branch_tgt;
                    end else begin
                        w_pc_nxt = r_pc + PC_ONE;
                    end
`endif
                end
            end
            DONE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_pc_nxt    = PC_INIT;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_pc_nxt    = PC_INIT;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_pc    <= PC_INIT;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

`ifdef PC_SEQUENCER_LINK_EN
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_link <= PC_INIT;
        end else begin
            r_link <= w_link_nxt;
        end
    end
`endif

    assign prog_counter = r_pc;
    assign running      = (r_state == RUN);
    assign done         = (r_state == DONE);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random
// stimulus, all checked against a behavioural model of the sequencer rules.
module tb_pc_sequencer;

    localparam int D         = 12;
    localparam int IMM_W     = 4;
    localparam int LUT_DEPTH = 16;
    localparam int SEL_W     = 4;
    localparam int PC_MOD    = 1 << D;

    logic             Clk = 1'b0;
    logic             Reset = 1'b0;
    logic             start = 1'b0;
    logic             halt = 1'b0;
    logic             stall = 1'b0;
    logic             branch_en = 1'b0;
    logic             imm_or_lut = 1'b0;
    logic             abs_sel = 1'b0;
    logic [IMM_W-1:0] pc_ctrl_input = '0;
    logic             lut_we = 1'b0;
    logic [SEL_W-1:0] lut_waddr = '0;
    logic [D-1:0]     lut_wdata = '0;
    logic [D-1:0]     prog_counter;
    logic             running;
    logic             done;

    int tests = 0;
    int fails = 0;

    // Behavioural model: PC as an integer, run/done flags, LUT as an int array.
    int m_pc;
    bit m_run;
    bit m_done;
    int m_lut [LUT_DEPTH];

    pc_sequencer #(
        .D         (D),
        .IMM_W     (IMM_W),
        .LUT_DEPTH (LUT_DEPTH)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .start         (start),
        .halt          (halt),
        .stall         (stall),
        .branch_en     (branch_en),
        .imm_or_lut    (imm_or_lut),
        .abs_sel       (abs_sel),
        .pc_ctrl_input (pc_ctrl_input),
        .lut_we        (lut_we),
        .lut_waddr     (lut_waddr),
        .lut_wdata     (lut_wdata),
        .prog_counter  (prog_counter),
        .running       (running),
        .done          (done)
    );

    always #5 Clk = ~Clk;

    function automatic int wrap(input int v);
        return ((v % PC_MOD) + PC_MOD) % PC_MOD;
    endfunction

    task automatic model_reset();
        m_pc   = 0;
        m_run  = 1'b0;
        m_done = 1'b0;
        foreach (m_lut[i]) m_lut[i] = 0;
    endtask

    // Applies one clock of the sequencer rules to the model using current inputs.
    task automatic model_step();
        int nxt;
        int imm;
        int idx;
        nxt = m_pc;
        idx = int'(pc_ctrl_input) % LUT_DEPTH;
        imm = int'(pc_ctrl_input);
        if (imm >= (1 << (IMM_W - 1))) imm -= (1 << IMM_W);
        if (!m_run) begin
            if (start) begin
                m_run  = 1'b1;
                m_done = 1'b0;
                nxt    = 0;
            end
        end else if (halt) begin
            m_run  = 1'b0;
            m_done = 1'b1;
        end else if (stall) begin
            nxt = m_pc;
        end else if (branch_en) begin
            if (!imm_or_lut)  nxt = wrap(m_pc + imm);
            else if (abs_sel) nxt = m_lut[idx];
            else              nxt = wrap(m_pc + m_lut[idx]);
        end else begin
            nxt = wrap(m_pc + 1);
        end
        if (lut_we) m_lut[int'(lut_waddr)] = int'(lut_wdata);
        m_pc = nxt;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, "_pc"},      32'(prog_counter), 32'(m_pc));
        check_eq({tag, "_running"}, 32'(running),      32'(m_run));
        check_eq({tag, "_done"},    32'(done),         32'(m_done));
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge Clk);
        #1;
        check_model(tag);
    endtask

    task automatic clear_inputs();
        start         = 1'b0;
        halt          = 1'b0;
        stall         = 1'b0;
        branch_en     = 1'b0;
        imm_or_lut    = 1'b0;
        abs_sel       = 1'b0;
        pc_ctrl_input = '0;
        lut_we        = 1'b0;
        lut_waddr     = '0;
        lut_wdata     = '0;
    endtask

    task automatic lut_write(input int idx, input int val);
        lut_we    = 1'b1;
        lut_waddr = SEL_W'(idx);
        lut_wdata = D'(val);
        tick("lut_wr");
        lut_we    = 1'b0;
    endtask

    task automatic lut_branch(input int idx, input bit is_abs);
        branch_en     = 1'b1;
        imm_or_lut    = 1'b1;
        abs_sel       = is_abs;
        pc_ctrl_input = IMM_W'(idx);
        tick(is_abs ? "lut_abs" : "lut_rel");
        branch_en     = 1'b0;
        imm_or_lut    = 1'b0;
        abs_sel       = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset and idle
        clear_inputs();
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        check_eq("reset_pc", 32'(prog_counter), 32'd0);
        check_eq("reset_running", 32'(running), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        Reset = 1'b1;
        tick("idle");
        tick("idle");

        // Start and sequential counting
        start = 1'b1;
        tick("start");
        start = 1'b0;
        check_eq("start_pc", 32'(prog_counter), 32'd0);
        check_eq("start_running", 32'(running), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            tick("count");
            check_eq("count_pc", 32'(prog_counter), 32'(k));
        end
        check_eq("count_done", 32'(done), 32'd0);
        repeat (7) tick("count");
        check_eq("reach_10", 32'(prog_counter), 32'd10);

        // Immediate branches
        branch_en     = 1'b1;
        pc_ctrl_input = 4'b1011;
        tick("imm_neg");
        branch_en     = 1'b0;
        check_eq("imm_neg_pc", 32'(prog_counter), 32'd5);
        repeat (5) tick("count");
        branch_en     = 1'b1;
        pc_ctrl_input = 4'b0111;
        tick("imm_pos");
        branch_en     = 1'b0;
        check_eq("imm_pos_pc", 32'(prog_counter), 32'd17);

        // LUT relative and absolute
        lut_write(3, 12'hF88);
        lut_write(15, 200);
        lut_write(14, 100);
        lut_write(13, 4095);
        lut_branch(15, 1'b1);
        check_eq("lut_abs_200", 32'(prog_counter), 32'd200);
        lut_branch(3, 1'b0);
        check_eq("lut_rel_80", 32'(prog_counter), 32'd80);
        lut_branch(15, 1'b1);
        lut_branch(3, 1'b1);
        check_eq("lut_abs_f88", 32'(prog_counter), 32'hF88);

        // Same-cycle write and branch-read of one index
        lut_branch(14, 1'b1);
        lut_we    = 1'b1;
        lut_waddr = 4'd3;
        lut_wdata = 12'd20;
        lut_branch(3, 1'b0);
        lut_we    = 1'b0;
        check_eq("collide_old", 32'(prog_counter), 32'd4076);
        lut_branch(3, 1'b0);
        check_eq("collide_new_wrap", 32'(prog_counter), 32'd0);

        // Increment wrap
        lut_branch(13, 1'b1);
        check_eq("max_pc", 32'(prog_counter), 32'd4095);
        tick("wrap");
        check_eq("wrap_pc", 32'(prog_counter), 32'd0);

        // Priorities: start ignored in RUN, stall over branch, halt over branch
        start = 1'b1;
        tick("start_in_run");
        start = 1'b0;
        check_eq("start_in_run_pc", 32'(prog_counter), 32'd1);
        stall         = 1'b1;
        branch_en     = 1'b1;
        pc_ctrl_input = 4'b0111;
        tick("stall_branch");
        stall         = 1'b0;
        check_eq("stall_pc", 32'(prog_counter), 32'd1);
        halt = 1'b1;
        tick("halt_branch");
        halt      = 1'b0;
        branch_en = 1'b0;
        check_eq("halt_pc", 32'(prog_counter), 32'd1);
        check_eq("halt_done", 32'(done), 32'd1);
        check_eq("halt_running", 32'(running), 32'd0);
        tick("done_hold");
        start = 1'b1;
        tick("restart");
        start = 1'b0;
        check_eq("restart_pc", 32'(prog_counter), 32'd0);
        check_eq("restart_running", 32'(running), 32'd1);

        // Random stimulus against the model
        for (int n = 0; n < 400; n++) begin
            start         = ($urandom_range(0, 15) == 0);
            halt          = ($urandom_range(0, 24) == 0);
            stall         = ($urandom_range(0, 4) == 0);
            branch_en     = ($urandom_range(0, 2) == 0);
            imm_or_lut    = $urandom_range(0, 1);
            abs_sel       = $urandom_range(0, 1);
            pc_ctrl_input = IMM_W'($urandom);
            lut_we        = ($urandom_range(0, 2) == 0);
            lut_waddr     = SEL_W'($urandom);
            lut_wdata     = D'($urandom);
            tick("rand");
        end
        clear_inputs();

        // Mid-run asynchronous reset
        tick("settle");
        start = 1'b1;
        tick("start2");
        start = 1'b0;
        lut_write(12, 37);
        lut_write(3, 20);
        lut_branch(12, 1'b1);
        check_eq("pc_37", 32'(prog_counter), 32'd37);
        #2;
        Reset = 1'b0;
        #1;
        model_reset();
        check_eq("async_rst_pc", 32'(prog_counter), 32'd0);
        check_model("async_rst");
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        check_model("rst_hold");
        start = 1'b1;
        tick("start3");
        start = 1'b0;
        tick("count");
        lut_branch(3, 1'b1);
        check_eq("lut_cleared_abs", 32'(prog_counter), 32'd0);
        tick("count");
        lut_branch(12, 1'b0);
        check_eq("lut_cleared_rel", 32'(prog_counter), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter unit: owns the PC register, the run/done control FSM, and a writable branch-offset LUT.
- Branch targets come from a sign-extended immediate or a LUT entry, applied as a relative offset or as an absolute address.
- Sits between the instruction-decode controller and the instruction ROM address input.
- Generalises the fixed-table branch-target generator with runtime-loadable depth/width, absolute mode, stall and halt.

Parameters:
- D, 12, PC / address width in bits.
- IMM_W, 4, width of the branch-control field from the instruction.
- LUT_DEPTH, 16, number of LUT entries. Must be a power of 2 and ≤ 2^IMM_W.
- SEL_W, $clog2(LUT_DEPTH), LUT index width. Derived; do not override.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset (asserted at 0).
- start  in  1  one-cycle pulse; begins or restarts execution.
- halt  in  1  decoded halt instruction.
- stall  in  1  freeze PC this cycle.
- branch_en  in  1  branch taken (condition already resolved).
- imm_or_lut  in  1  1 = LUT entry, 0 = sign-extended immediate.
- abs_sel  in  1  1 = LUT value is an absolute target (ignored when imm_or_lut=0).
- pc_ctrl_input  in  IMM_W  immediate, or LUT index (low SEL_W bits).
- lut_we  in  1  LUT write enable.
- lut_waddr  in  SEL_W  LUT write index.
- lut_wdata  in  D  LUT write data (signed offset or absolute address).
- prog_counter  out  D  current PC, registered.
- running  out  1  FSM in RUN.
- done  out  1  FSM in DONE.

Behaviour:
- Reset (async, Reset=0): prog_counter=0, FSM=IDLE, running=0, done=0, every LUT entry=0.
- FSM states: IDLE, RUN, DONE. running and done are decoded registered state bits, asserted only in RUN and DONE respectively.
- IDLE: PC holds 0. start → RUN, PC=0.
- RUN: start is ignored. Per cycle, the first matching row applies:
  - halt → DONE, PC holds.
  - stall → PC holds, including when branch_en=1.
  - branch_en:
    - imm_or_lut=0: PC ← PC + sext(pc_ctrl_input).
    - imm_or_lut=1, abs_sel=0: PC ← PC + LUT[idx].
    - imm_or_lut=1, abs_sel=1: PC ← LUT[idx].
  - otherwise: PC ← PC + 1.
- DONE: PC holds. start → RUN, PC=0.
- Arithmetic: all sums are modulo 2^D; wrap-around is silent (PC=2^D−1 +1 → 0). A zero offset holds the PC, which is legal.
- LUT index: idx = pc_ctrl_input[SEL_W-1:0]. Upper immediate bits are ignored in LUT mode.
- LUT read is combinational; LUT write is synchronous.
  - Write and branch-read of the same index in one cycle: the branch uses the old value; the new value is visible next cycle.
  - Writes are accepted in every FSM state.
- Latency: PC update visible one cycle after the controlling inputs.
- Reset mid-RUN forces IDLE and PC=0 immediately. LUT contents are lost.

Optional Feature:
- Macro: PC_SEQUENCER_LINK_EN.
- Defined: adds ports call (in, 1), ret (in, 1) and link_addr (out, D), plus a one-deep link register, reset value 0.
  - call: acts as branch_en; additionally link ← PC+1.
  - ret: PC ← link.
  - call and ret together: ret wins and link is unchanged.
  - stall and halt override both.
- Undefined: no link ports or register; behaviour exactly as above.

Decomposition:
- Package pc_seq_pkg:
  - FSM enum typedef (IDLE/RUN/DONE, 2-bit).
  - PC_RESET constant (0).
  - Helper function sext_imm(IMM_W→D).
- Sub-module branch_lut: parametrised register file of LUT_DEPTH×D, with async reset, one sync write port and one comb read port.
- FSM, next-PC mux and link register stay in pc_sequencer.

Test Plan:
- Reset/start: Reset=0 then 1, start pulse → running=1, prog_counter 0,1,2,3 on successive cycles; done=0.
- Immediate branch: at PC=10, branch_en=1, imm_or_lut=0, pc_ctrl_input=4'b1011 → PC=5 next cycle; pc_ctrl_input=4'b0111 → PC=17.
- LUT relative/absolute: write LUT[3]=12'hF88 (−120); at PC=200 branch with idx 3, abs_sel=0 → PC=80. Same branch with abs_sel=1 → PC=0xF88.
- Write/read collision: same-cycle write LUT[3]=20 with branch idx 3 at PC=100 → PC=100+old LUT[3]; the next branch uses 20.
- Priority and wrap: PC=4095 with no control → PC=0. halt+branch_en → DONE and PC holds. stall+branch_en → PC holds. start in DONE → PC=0, running=1.
- Mid-run reset: Reset=0 while PC=37 in RUN → prog_counter=0 and IDLE within the same cycle; LUT reads back 0.
